// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one single-ported RAM: IDLE -> ACCESS -> DONE per access.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: req0 fixed priority).
module ram_arbiter #(
  parameter int unsigned BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [BUS_WIDTH-1:0] addr0,
  input  logic [BUS_WIDTH-1:0] addr1,
  input  logic [BUS_WIDTH-1:0] wdata0,
  input  logic [BUS_WIDTH-1:0] wdata1,
  output logic                 done0,
  output logic                 done1,
  output logic [BUS_WIDTH-1:0] rdata0,
  output logic [BUS_WIDTH-1:0] rdata1,
  output logic                 ram_write_en,
  output logic [BUS_WIDTH-1:0] ram_addr_write,
  output logic [BUS_WIDTH-1:0] ram_addr_read,
  output logic [BUS_WIDTH-1:0] ram_data_write,
  input  logic [BUS_WIDTH-1:0] ram_data_read,
  input  logic                 ram_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t               state;
  logic                 owner;
  logic                 we_lat;
  logic [BUS_WIDTH-1:0] addr_lat;
  logic [BUS_WIDTH-1:0] wdata_lat;

  logic                 grant_sel;
  logic                 grant_we;
  logic [BUS_WIDTH-1:0] grant_addr;
  logic [BUS_WIDTH-1:0] grant_wdata;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  logic last_owner;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    grant_sel = 1'b0;
    if (req1 && (!req0 || !last_owner))
      grant_sel = 1'b1;
  end
`else
  always_comb begin
    grant_sel = 1'b0;
    if (req1 && !req0)
      grant_sel = 1'b1;
  end
`endif

  always_comb begin
    grant_we    = grant_sel ? we1    : we0;
    grant_addr  = grant_sel ? addr1  : addr0;
    grant_wdata = grant_sel ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      owner        <= 1'b0;
      we_lat       <= 1'b0;
      addr_lat     <= '0;
      wdata_lat    <= '0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      ram_write_en <= 1'b0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      last_owner   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (ram_ready && (req0 || req1)) begin
            owner        <= grant_sel;
            we_lat       <= grant_we;
            addr_lat     <= grant_addr;
            wdata_lat    <= grant_wdata;
            ram_write_en <= grant_we;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            last_owner   <= grant_sel;
`endif
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          ram_write_en <= 1'b0;
          if (!we_lat) begin
            if (owner)
              rdata1 <= ram_data_read;
            else
              rdata0 <= ram_data_read;
          end
          done0 <= !owner;
          done1 <= owner;
          state <= DONE;
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done0        <= 1'b0;
          done1        <= 1'b0;
          ram_write_en <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign ram_addr_write = addr_lat;
  assign ram_addr_read  = addr_lat;
  assign ram_data_write = wdata_lat;

endmodule
